vcdl_phase_scan_ctrl: RTL
=========================

Name: vcdl_phase_scan_ctrl

Overview:
Sequences the VCDL generator's sync-path IDELAY to find the VCDL phase edge. For each tap 0..31 it loads the tap, waits a settle time, and counts high samples of the delayed sync signal over a fixed window. It reports the first low-to-high threshold crossing, then leaves the IDELAY loaded with that tap. Sits between the register interface and the VCDL generator's en_i, delay_i and load_delay_i inputs; in manual mode it passes delay writes through.

Parameters:
LOG_SAMPLES, 8, log2 of samples per tap; window = 2^LOG_SAMPLES cycles.
THRESHOLD, 128, high-count at or above which a tap reads "high"; width LOG_SAMPLES+1.
SETTLE_CYCLES, 16, idle cycles after each load before sampling; must be 1..255.

Ports:
CLK  input  1  system clock; all logic on its rising edge.
rst_n_i  input  1  asynchronous active-low reset.
start_i  input  1  one-cycle pulse; begins a scan when idle.
abort_i  input  1  level; ends a scan and returns to IDLE.
idelayctrl_rdy_i  input  1  IDELAYCTRL ready.
vcdl_sync_i  input  1  delayed sync from the IDELAY.
manual_delay_i  input  5  tap for manual load.
manual_load_i  input  1  one-cycle manual load request.
en_o  output  1  drives generator en_i.
delay_o  output  5  drives generator delay_i.
load_delay_o  output  1  drives generator load_delay_i; always a one-cycle pulse.
busy_o  output  1  high outside IDLE.
done_o  output  1  one-cycle pulse at scan end.
edge_found_o  output  1  result flag; held until the next start.
edge_tap_o  output  5  detected tap; held.
count_o  output  LOG_SAMPLES+1  high-count of the last measured tap.
count_tap_o  output  5  tap that count_o belongs to.
count_valid_o  output  1  one-cycle pulse when count_o updates.

Behaviour:
- Reset (async assert, sync release): state IDLE; every output 0; internal tap, counters and prev_high cleared.
- IDLE:
  - en_o=0; busy_o=0.
  - manual_load_i: delay_o<=manual_delay_i and load_delay_o=1 on the next cycle.
  - start_i: clear edge_found_o, edge_tap_o and prev_high; tap=0; go to WAIT_RDY. start_i is ignored outside IDLE.
  - start_i and manual_load_i together: start wins; no manual load.
- WAIT_RDY: en_o=1; stay until idelayctrl_rdy_i=1, then go to LOAD.
- LOAD: delay_o=tap; load_delay_o=1 for exactly this cycle; go to SETTLE.
- SETTLE: run SETTLE_CYCLES cycles; then clear the sample counter and high-count and go to MEASURE.
- MEASURE:
  - Register vcdl_sync_i once (sample path latency 1).
  - Accumulate registered highs over exactly 2^LOG_SAMPLES samples.
  - The high-count saturates naturally at 2^LOG_SAMPLES; no overflow, given width LOG_SAMPLES+1.
  - Then go to RECORD.
- RECORD (1 cycle):
  - count_o<=high-count; count_tap_o<=tap; count_valid_o=1.
  - cur_high = (count >= THRESHOLD).
  - If !edge_found and tap!=0 and !prev_high and cur_high: edge_found_o<=1, edge_tap_o<=tap.
  - Tap 0 never produces an edge.
  - prev_high<=cur_high.
  - If tap==31 go to FINAL; else tap+1 and go to LOAD. Tap never wraps.
- FINAL:
  - Load edge_tap_o if found, else tap 0: one-cycle load_delay_o.
  - Then done_o pulse and return to IDLE.
  - en_o stays 1 through FINAL and drops in IDLE.
- abort_i in any state except IDLE:
  - Next state IDLE; no done_o; no FINAL load.
  - edge_found_o and edge_tap_o hold partial results.
  - A load pulse already in flight completes its single cycle.
- idelayctrl_rdy_i dropping mid-scan is ignored; the scan runs to completion.
- Per-tap cost: 1 (LOAD) + SETTLE_CYCLES + 2^LOG_SAMPLES + 1 (RECORD) cycles.
- Full scan: 32 x per-tap cost, plus WAIT_RDY, plus 1 FINAL cycle.

Test Plan:
- Edge at tap 13: vcdl_sync_i=0 for taps 0-12 and 1 for taps 13-31, rdy=1, start pulse -> 32 count_valid pulses; counts 0 then 256; edge_found=1; edge_tap=13; final load with delay_o=13; done once; total cycles 1+32*274+1.
- No edge: vcdl_sync_i stuck 1 -> every count=256; edge_found=0; final load of tap 0; done pulses.
- Threshold boundary: taps 0-9 give 127 highs, tap 10 gives 128 highs -> edge_tap=10. Repeat with tap 10 giving 127 highs -> no edge at tap 10.
- Ready gating: rdy=0 for 500 cycles after start -> en_o=1, busy_o=1, no load pulse until rdy rises; first load with delay_o=0 one cycle after rdy.
- Abort: assert abort_i during MEASURE at tap 5 -> IDLE next cycle; busy_o=0; en_o=0; no done_o; no further load pulses. A subsequent start rescans from tap 0.
- Manual and reset: in IDLE, manual_load_i with manual_delay_i=22 -> delay_o=22, one-cycle load. rst_n_i low mid-SETTLE -> all outputs 0 immediately (async).

Source files
------------

// File: rtl/vcdl_phase_scan_ctrl_if.sv
// Register-side / VCDL-generator-side signal bundle of the phase scan controller.
// The master modport is the controlling side; the slave modport is the scan controller.
interface vcdl_phase_scan_ctrl_if #(
  parameter int LOG_SAMPLES = 8
);
  logic                   start_i;
  logic                   abort_i;
  logic                   idelayctrl_rdy_i;
  logic                   vcdl_sync_i;
  logic [4:0]             manual_delay_i;
  logic                   manual_load_i;
  logic                   en_o;
  logic [4:0]             delay_o;
  logic                   load_delay_o;
  logic                   busy_o;
  logic                   done_o;
  logic                   edge_found_o;
  logic [4:0]             edge_tap_o;
  logic [LOG_SAMPLES:0]   count_o;
  logic [4:0]             count_tap_o;
  logic                   count_valid_o;

  modport master (
    output start_i, abort_i, idelayctrl_rdy_i, vcdl_sync_i, manual_delay_i, manual_load_i,
    input  en_o, delay_o, load_delay_o, busy_o, done_o, edge_found_o, edge_tap_o,
           count_o, count_tap_o, count_valid_o
  );

  modport slave (
    input  start_i, abort_i, idelayctrl_rdy_i, vcdl_sync_i, manual_delay_i, manual_load_i,
    output en_o, delay_o, load_delay_o, busy_o, done_o, edge_found_o, edge_tap_o,
           count_o, count_tap_o, count_valid_o
  );
endinterface

// File: rtl/vcdl_phase_scan_ctrl.sv
// Steps the sync-path IDELAY through taps 0..31, measures the high ratio of the delayed
// sync at each tap and reports (and finally loads) the first low-to-high crossing.
module vcdl_phase_scan_ctrl #(
  parameter int LOG_SAMPLES   = 8,
  parameter int THRESHOLD     = 128,
  parameter int SETTLE_CYCLES = 16
) (
  input logic                       CLK,
  input logic                       rst_n_i,
  vcdl_phase_scan_ctrl_if.slave     bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_RDY, S_LOAD, S_SETTLE, S_MEASURE, S_RECORD, S_FINAL
  } state_t;

  localparam logic [LOG_SAMPLES-1:0] SAMP_ONE    = 1;
  localparam logic [LOG_SAMPLES:0]   THRESH_W    = (LOG_SAMPLES+1)'(THRESHOLD);
  localparam logic [7:0]             SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

  state_t                 state, next_state;
  logic [4:0]             tap;
  logic [7:0]             settle_cnt;
  logic [LOG_SAMPLES-1:0] samp_cnt;
  logic [LOG_SAMPLES:0]   high_cnt;
  logic                   prev_high;
  logic                   sync_r;
  logic [4:0]             delay_r;
  logic                   load_r;
  logic                   edge_found_r;
  logic [4:0]             edge_tap_r;
  logic [LOG_SAMPLES:0]   count_r;
  logic [4:0]             count_tap_r;
  logic                   count_valid_r;

  logic       start_acc, manual_acc, settle_last, meas_last, cur_high, new_edge;
  logic [4:0] load_tap, final_tap;

  assign start_acc   = (state == S_IDLE) && bus.start_i;
  assign manual_acc  = (state == S_IDLE) && bus.manual_load_i && !bus.start_i;
  assign settle_last = (settle_cnt == SETTLE_LAST);
  assign meas_last   = &samp_cnt;
  assign cur_high    = (high_cnt >= THRESH_W);
  assign new_edge    = (state == S_RECORD) && !edge_found_r && (tap != 5'd0) && !prev_high && cur_high;
  assign load_tap    = (state == S_RECORD) ? tap + 5'd1 : tap;
  assign final_tap   = new_edge ? tap : edge_tap_r;

  always_ff @(posedge CLK or negedge rst_n_i) begin
    if (!rst_n_i) state <= S_IDLE;
    else          state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:     if (bus.start_i) next_state = S_WAIT_RDY;
      S_WAIT_RDY: if (bus.idelayctrl_rdy_i) next_state = S_LOAD;
      S_LOAD:     next_state = S_SETTLE;
      S_SETTLE:   if (settle_last) next_state = S_MEASURE;
      S_MEASURE:  if (meas_last) next_state = S_RECORD;
      S_RECORD:   next_state = (tap == 5'd31) ? S_FINAL : S_LOAD;
      S_FINAL:    next_state = S_IDLE;
      default:    next_state = S_IDLE;
    endcase
    // Abort suppresses any further load, so a pulse already issued is the last one.
    if (bus.abort_i && state != S_IDLE) next_state = S_IDLE;
  end

  always_comb begin
    bus.en_o   = 1'b0;
    bus.busy_o = 1'b0;
    bus.done_o = 1'b0;
    if (state != S_IDLE) begin
      bus.en_o   = 1'b1;
      bus.busy_o = 1'b1;
    end
    if (state == S_FINAL && !bus.abort_i) bus.done_o = 1'b1;
  end

  always_ff @(posedge CLK or negedge rst_n_i) begin
    if (!rst_n_i) begin
      tap           <= '0;
      settle_cnt    <= '0;
      samp_cnt      <= '0;
      high_cnt      <= '0;
      prev_high     <= 1'b0;
      sync_r        <= 1'b0;
      delay_r       <= '0;
      load_r        <= 1'b0;
      edge_found_r  <= 1'b0;
      edge_tap_r    <= '0;
      count_r       <= '0;
      count_tap_r   <= '0;
      count_valid_r <= 1'b0;
    end else begin
      sync_r        <= bus.vcdl_sync_i;
      load_r        <= 1'b0;
      count_valid_r <= 1'b0;
      // Loads are registered one cycle ahead so the pulse coincides with LOAD/FINAL.
      if (manual_acc) begin
        delay_r <= bus.manual_delay_i;
        load_r  <= 1'b1;
      end else if (next_state == S_LOAD) begin
        delay_r <= load_tap;
        load_r  <= 1'b1;
      end else if (next_state == S_FINAL) begin
        delay_r <= final_tap;
        load_r  <= 1'b1;
      end
      case (state)
        S_IDLE: begin
          if (start_acc) begin
            edge_found_r <= 1'b0;
            edge_tap_r   <= '0;
            prev_high    <= 1'b0;
            tap          <= '0;
          end
        end
        S_LOAD: settle_cnt <= '0;
        S_SETTLE: begin
          settle_cnt <= settle_cnt + 8'd1;
          if (settle_last) begin
            samp_cnt <= '0;
            high_cnt <= '0;
          end
        end
        S_MEASURE: begin
          samp_cnt <= samp_cnt + SAMP_ONE;
          high_cnt <= high_cnt + {{LOG_SAMPLES{1'b0}}, sync_r};
        end
        S_RECORD: begin
          count_r       <= high_cnt;
          count_tap_r   <= tap;
          count_valid_r <= 1'b1;
          prev_high     <= cur_high;
          if (new_edge) begin
            edge_found_r <= 1'b1;
            edge_tap_r   <= tap;
          end
          if (tap != 5'd31) tap <= tap + 5'd1;
        end
        default: ;
      endcase
    end
  end

  assign bus.delay_o       = delay_r;
  assign bus.load_delay_o  = load_r;
  assign bus.edge_found_o  = edge_found_r;
  assign bus.edge_tap_o    = edge_tap_r;
  assign bus.count_o       = count_r;
  assign bus.count_tap_o   = count_tap_r;
  assign bus.count_valid_o = count_valid_r;

endmodule
